fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 59 +++++
 rtl/fetch_queue_mem.sv | 40 ++++
 rtl/fetch_queue.sv | 146 ++++++++++++++
 tb/tb_fetch_queue.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared definitions for the instruction fetch queue.
//   excp_t       : fetch-side exception code carried with each instruction
//   fetch_pkt_t  : one queue entry (pc, inst, prediction, exception info)
//   make_fetch_pkt() : bundles the individual fetch fields into a fetch_pkt_t
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

   // Fetch-side exception codes. NO_EXCP is zero so that a cleared
   // storage slot reads back as "no exception".
   typedef enum logic [5:0] {
      NO_EXCP = 6'h00,
      INT     = 6'h01,
      PIL     = 6'h02,
      PIS     = 6'h03,
      PIF     = 6'h04,
      PME     = 6'h05,
      PPI     = 6'h07,
      ADEF    = 6'h08,
      ALE     = 6'h09,
      SYS     = 6'h0b,
      BRK     = 6'h0c,
      INE     = 6'h0d,
      IPE     = 6'h0e,
      FPE     = 6'h0f,
      TLBR    = 6'h3f
   } excp_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred_br_taken;
      logic [31:0] pred_br_target;
      logic        have_excp;
      excp_t       excp_type;
   } fetch_pkt_t;

   localparam int FETCH_PKT_W = $bits(fetch_pkt_t);

   function automatic fetch_pkt_t make_fetch_pkt(
      input logic [31:0] pc,
      input logic [31:0] inst,
      input logic        pred_br_taken,
      input logic [31:0] pred_br_target,
      input logic        have_excp,
      input excp_t       excp_type
   );
      fetch_pkt_t p;
      p.pc             = pc;
      p.inst           = inst;
      p.pred_br_taken  = pred_br_taken;
      p.pred_br_target = pred_br_target;
      p.have_excp      = have_excp;
      p.excp_type      = excp_type;
      return p;
   endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// -----------------------------------------------------------------------------
// fetch_queue_mem
// Entry storage for fetch_queue: DEPTH x fetch_pkt_t, one synchronous write
// port and one asynchronous (combinational) read port. All slots are cleared
// asynchronously by reset so the read port returns zero after reset.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data : write port, captured on the rising edge
//   rd_addr/rd_data     : combinational read port
// -----------------------------------------------------------------------------
module fetch_queue_mem
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  fetch_pkt_t    wr_data,
   input  logic [AW-1:0] rd_addr,
   output fetch_pkt_t    rd_data
);

   fetch_pkt_t mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction fetch queue between the fetch stage and the decoder.
// Holds up to DEPTH fetched instructions in FIFO order; flush discards
// everything (branch redirect / exception).
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. The producer holds its payload stable while valid=1 and
// ready=0; in_ready never depends on in_valid. out_* payload is meaningful
// only while out_valid=1 (otherwise it shows the head storage slot).
//
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   flush                  : drop all queued and incoming instructions
//   in_valid/in_ready      : enqueue handshake
//   in_pc .. in_excp_type  : enqueue payload
//   out_valid/out_ready    : dequeue handshake
//   out_pc .. out_excp_type: head entry payload
//   count                  : number of valid entries (0..DEPTH)
//
// Build option: FETCH_QUEUE_BYPASS_EN -- when defined, an instruction arriving
// at an empty queue is presented on out_* in the same cycle; if the decoder
// takes it immediately it is never written into storage.
// -----------------------------------------------------------------------------
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,

   input  logic          in_valid,
   input  logic [31:0]   in_pc,
   input  logic [31:0]   in_inst,
   input  logic          in_pred_br_taken,
   input  logic [31:0]   in_pred_br_target,
   input  logic          in_have_excp,
   input  excp_t         in_excp_type,
   output logic          in_ready,

   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_pc,
   output logic [31:0]   out_inst,
   output logic          out_pred_br_taken,
   output logic [31:0]   out_pred_br_target,
   output logic          out_have_excp,
   output excp_t         out_excp_type,

   output logic [CW-1:0] count
);

   logic [AW-1:0] head;
   logic [AW-1:0] tail;

   fetch_pkt_t in_pkt;
   fetch_pkt_t rd_pkt;
   fetch_pkt_t out_pkt;

   logic empty;
   logic full;
   logic bypass;
   logic enq;
   logic deq;

   assign in_pkt = make_fetch_pkt(in_pc, in_inst, in_pred_br_taken,
                                  in_pred_br_target, in_have_excp,
                                  in_excp_type);

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // Space is judged on the registered count only: a dequeue in the same
   // cycle does not make room for an enqueue while full.
   assign in_ready = !full && !flush && !reset;

`ifdef FETCH_QUEUE_BYPASS_EN
   // Empty queue: hand the incoming instruction straight to the decoder.
   assign bypass  = empty && in_valid && !flush && !reset;
   assign out_pkt = bypass ? in_pkt : rd_pkt;
`else
   // No path from in_* to out_*: an entry becomes visible one cycle after
   // it is written.
   assign bypass  = 1'b0;
   assign out_pkt = rd_pkt;
`endif

   assign out_valid = (!empty || bypass) && !flush;

   // A bypassed instruction taken by the decoder this cycle is consumed
   // without touching storage; otherwise it is enqueued as usual.
   assign enq = in_valid && in_ready && !(bypass && out_ready);

   // Storage dequeue only; the bypass case never pops storage since the
   // queue is empty then.
   assign deq = !empty && !flush && out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         // DEPTH is a power of two, so natural pointer overflow is the wrap.
         if (enq) begin
            tail <= tail + AW'(1);
         end
         if (deq) begin
            head <= head + AW'(1);
         end
         unique case ({enq, deq})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   fetch_queue_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (enq),
      .wr_addr (tail),
      .wr_data (in_pkt),
      .rd_addr (head),
      .rd_data (rd_pkt)
   );

   assign out_pc             = out_pkt.pc;
   assign out_inst           = out_pkt.inst;
   assign out_pred_br_taken  = out_pkt.pred_br_taken;
   assign out_pred_br_target = out_pkt.pred_br_target;
   assign out_have_excp      = out_pkt.have_excp;
   assign out_excp_type      = out_pkt.excp_type;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue (DEPTH=8). A queue-based model predicts
// count/in_ready/out_valid/head payload every cycle; directed scenarios add
// literal expectations on top. Honors FETCH_QUEUE_BYPASS_EN like the DUT.
// -----------------------------------------------------------------------------
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = 8;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   fetch_pkt_t  in_pkt;

   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_pred_br_taken;
   logic [31:0] out_pred_br_target;
   logic        out_have_excp;
   excp_t       out_excp_type;
   logic [3:0]  count;
   fetch_pkt_t  dut_pkt;

   assign dut_pkt = fetch_pkt_t'({out_pc, out_inst, out_pred_br_taken,
                                  out_pred_br_target, out_have_excp,
                                  out_excp_type});

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk                (clk),
      .reset              (reset),
      .flush              (flush),
      .in_valid           (in_valid),
      .in_pc              (in_pkt.pc),
      .in_inst            (in_pkt.inst),
      .in_pred_br_taken   (in_pkt.pred_br_taken),
      .in_pred_br_target  (in_pkt.pred_br_target),
      .in_have_excp       (in_pkt.have_excp),
      .in_excp_type       (in_pkt.excp_type),
      .in_ready           (in_ready),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_pc             (out_pc),
      .out_inst           (out_inst),
      .out_pred_br_taken  (out_pred_br_taken),
      .out_pred_br_target (out_pred_br_target),
      .out_have_excp      (out_have_excp),
      .out_excp_type      (out_excp_type),
      .count              (count)
   );

   // ---------------- scoreboard ----------------
   int n_vec  = 0;
   int n_fail = 0;
   fetch_pkt_t  exp_q[$];
   logic [31:0] deq_log[$];

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: queue of packets; rules applied from the interface contract.
   always @(negedge clk) begin
      logic exp_byp, exp_ov, exp_ir, m_enq, m_deq;
      if (reset) exp_q.delete();
      exp_byp = BYP && (exp_q.size() == 0) && in_valid && !flush && !reset;
      exp_ir  = (exp_q.size() != DEPTH) && !flush && !reset;
      exp_ov  = ((exp_q.size() != 0) || exp_byp) && !flush;
      chk("count", 128'(count), 128'(exp_q.size()));
      chk("in_ready", 128'(in_ready), 128'(exp_ir));
      chk("out_valid", 128'(out_valid), 128'(exp_ov));
      if (exp_ov)
         chk("out_pkt", 128'(dut_pkt), 128'(exp_byp ? in_pkt : exp_q[0]));
      else if (reset)
         chk("out_pkt_reset", 128'(dut_pkt), 128'(0));
      if (out_valid && out_ready) deq_log.push_back(out_pc);
      if (!reset) begin
         if (flush) begin
            exp_q.delete();
         end else begin
            m_enq = in_valid && (exp_q.size() != DEPTH) && !(exp_byp && out_ready);
            m_deq = (exp_q.size() != 0) && out_ready;
            if (m_deq) void'(exp_q.pop_front());
            if (m_enq) exp_q.push_back(in_pkt);
         end
      end
   end

   // ---------------- driver tasks ----------------
   function automatic fetch_pkt_t mk(input logic [31:0] pc);
      return make_fetch_pkt(pc, ~pc, pc[2], pc + 32'h100, 1'b0, NO_EXCP);
   endfunction

   task automatic setin(input logic v, input fetch_pkt_t p, input logic rdy,
                        input logic fl);
      in_valid  = v;
      in_pkt    = p;
      out_ready = rdy;
      flush     = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         setin(1'b1, mk(base + 32'(4 * i)), 1'b0, 1'b0);
         tick();
      end
      setin(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic chk_log(input string name, input logic [31:0] base,
                          input int n);
      chk({name, "_len"}, 128'(deq_log.size()), 128'(n));
      for (int i = 0; i < n && i < deq_log.size(); i++)
         chk({name, "_pc"}, 128'(deq_log[i]), 128'(base + 32'(4 * i)));
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      fetch_pkt_t ep;
      reset = 1'b1;
      setin(1'b0, '0, 1'b0, 1'b0);
      repeat (3) tick();
      chk("rst_count", 128'(count), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      reset = 1'b0;
      #1;
      chk("in_ready_after_rst", 128'(in_ready), 128'(1));
      tick();

      // Fill to full, then drain in order.
      fill(32'h1c00_0000, 8);
      #1;
      chk("full_count", 128'(count), 128'(8));
      chk("full_in_ready", 128'(in_ready), 128'(0));
      deq_log.delete();
      setin(1'b0, '0, 1'b1, 1'b0);
      repeat (8) tick();
      chk("drain_count", 128'(count), 128'(0));
      chk_log("drain", 32'h1c00_0000, 8);

      // Full with simultaneous enqueue+dequeue: only the dequeue happens.
      fill(32'h1c00_0200, 8);
      setin(1'b1, mk(32'h1c00_0300), 1'b1, 1'b0);
      tick();
      setin(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("full_both_count", 128'(count), 128'(7));
      chk("full_both_in_ready", 128'(in_ready), 128'(1));
      deq_log.delete();
      setin(1'b0, '0, 1'b1, 1'b0);
      repeat (7) tick();
      chk_log("full_both", 32'h1c00_0204, 7);

      // 20 back-to-back enq+deq across pointer wrap.
      setin(1'b1, mk(32'h1c00_1000), 1'b0, 1'b0);
      tick();
      deq_log.delete();
      for (int i = 1; i <= 20; i++) begin
         setin(1'b1, mk(32'h1c00_1000 + 32'(4 * i)), 1'b1, 1'b0);
         tick();
         chk("wrap_count", 128'(count), 128'(1));
      end
      setin(1'b0, '0, 1'b1, 1'b0);
      tick();
      chk_log("wrap", 32'h1c00_1000, 21);
      chk("wrap_end_count", 128'(count), 128'(0));

      // Flush with 5 entries and an incoming instruction.
      fill(32'h1c00_2000, 5);
      setin(1'b1, mk(32'h1c00_20f0), 1'b1, 1'b1);
      #2;
      chk("flush_out_valid", 128'(out_valid), 128'(0));
      chk("flush_in_ready", 128'(in_ready), 128'(0));
      deq_log.delete();
      tick();
      setin(1'b0, '0, 1'b1, 1'b0);
      #1;
      chk("post_flush_count", 128'(count), 128'(0));
      repeat (3) tick();
      chk("post_flush_log", 128'(deq_log.size()), 128'(0));

      // All fields bit-exact through the queue.
      ep = make_fetch_pkt(32'h1c00_0080, 32'h0280_0c21, 1'b1, 32'h1c00_0100,
                          1'b1, ADEF);
      setin(1'b1, ep, 1'b0, 1'b0);
      tick();
      setin(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("excp_valid", 128'(out_valid), 128'(1));
      chk("excp_pc", 128'(out_pc), 128'(32'h1c00_0080));
      chk("excp_inst", 128'(out_inst), 128'(32'h0280_0c21));
      chk("excp_taken", 128'(out_pred_br_taken), 128'(1));
      chk("excp_target", 128'(out_pred_br_target), 128'(32'h1c00_0100));
      chk("excp_flag", 128'(out_have_excp), 128'(1));
      chk("excp_type", 128'(out_excp_type), 128'(6'h08));
      setin(1'b0, '0, 1'b1, 1'b0);
      tick();
      chk("excp_drained", 128'(count), 128'(0));

      // Empty queue, instruction arriving with decoder ready.
      setin(1'b1, mk(32'h1c00_0040), 1'b1, 1'b0);
      #2;
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("byp_out_valid", 128'(out_valid), 128'(1));
      chk("byp_out_pc", 128'(out_pc), 128'(32'h1c00_0040));
`else
      chk("nobyp_out_valid", 128'(out_valid), 128'(0));
`endif
      chk("byp_count_same", 128'(count), 128'(0));
      tick();
      setin(1'b0, '0, 1'b1, 1'b0);
      #1;
      chk("byp_count_next", 128'(count), 128'(BYP ? 0 : 1));
      tick();

      // Asynchronous reset in the middle of operation.
      fill(32'h1c00_4000, 3);
      #1;
      reset = 1'b1;
      #1;
      chk("midrst_count", 128'(count), 128'(0));
      chk("midrst_out_valid", 128'(out_valid), 128'(0));
      chk("midrst_in_ready", 128'(in_ready), 128'(0));
      chk("midrst_out_pc", 128'(out_pc), 128'(0));
      tick();
      reset = 1'b0;
      deq_log.delete();
      setin(1'b0, '0, 1'b1, 1'b0);
      repeat (2) tick();
      chk("midrst_after_count", 128'(count), 128'(0));
      chk("midrst_after_log", 128'(deq_log.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   // Bound on total runtime.
   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
